// File: rtl/shift_add_mul_seq_if.sv
// Operand/product handshake bundle for the shift-add MUL unit.
// master: the requester/consumer side; slave: the multiplier itself.
interface shift_add_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier (low 32 bits of a*b) and the
// 32-bit two-level carry-lookahead adder it steps through once per cycle.

// 32-bit carry-lookahead adder, carry-in 0, carry-out not produced.
// Eight 4-bit groups; group carries are fully expanded from group G/P.
module Add (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic [31:0] p;
  logic [30:0] g;   // bit 31 generate would only feed the dropped carry-out
  logic [6:0]  gg;  // group generate, groups 0..6
  logic [6:1]  pg;  // group propagate, groups 1..6
  logic [7:0]  gc;  // carry into each group
  logic [31:0] c;   // carry into each bit

  assign p = a_i ^ b_i;
  assign g = a_i[30:0] & b_i[30:0];

  // Group generate/propagate terms
  always_comb begin
    gg = '0;
    pg = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    for (int unsigned k = 1; k < 7; k++) begin
      pg[k] = &p[4*k +: 4];
    end
  end

  // Lookahead group carries: gc[k] = OR_j<k ( gg[j] & pg[j+1..k-1] )
  always_comb begin
    logic term;
    logic acc;
    gc   = '0;
    term = 1'b0;
    acc  = 1'b0;
    for (int unsigned k = 1; k < 8; k++) begin
      acc = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        term = gg[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          term = term & pg[m];
        end
        acc = acc | term;
      end
      gc[k] = acc;
    end
  end

  // Per-bit carries inside each group, looked ahead from the group carry-in
  always_comb begin
    c = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum_o = p ^ c;
endmodule

module shift_add_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  shift_add_mul_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] add_sum;
  logic        in_ready_w;

  Add u_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (add_sum)
  );

  assign in_ready_w    = (state_q == IDLE) && !rst;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = acc_q;
  assign bus.busy      = (state_q != IDLE);

  // Next-state and datapath step: accept in IDLE, one partial product per BUSY cycle
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        // Exit on the 32nd step, or as soon as no multiplier ones remain
        if ((count_q == 5'd31) || (EARLY_EXIT && (mplier_q[31:1] == '0))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Directed and streaming checks for shift_add_mul_seq, both exit modes.
module tb_shift_add_mul_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_add_mul_seq_if bus_e ();
  shift_add_mul_seq_if bus_f ();

  shift_add_mul_seq #(.EARLY_EXIT(1'b1)) u_dut_e (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  shift_add_mul_seq #(.EARLY_EXIT(1'b0)) u_dut_f (
    .clk (clk),
    .rst (rst),
    .bus (bus_f.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One operation on the early-exit unit; called #1 after a posedge in IDLE
  task automatic op_e(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_p, input logic [31:0] exp_l,
                      input string tag);
    int   n;
    logic busy_ok;
    bus_e.in_valid = 1'b1;
    bus_e.a        = a;
    bus_e.b        = b;
    check({tag, "_rdy"}, {31'd0, bus_e.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus_e.in_valid = 1'b0;
    bus_e.a        = $urandom;
    bus_e.b        = $urandom;
    n       = 0;
    busy_ok = 1'b1;
    while (!bus_e.out_valid && n < 40) begin
      if (!bus_e.busy || bus_e.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_l);
    check({tag, "_prod"}, bus_e.product, exp_p);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    bus_e.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_e.out_ready = 1'b0;
    check({tag, "_idle"}, {29'd0, bus_e.out_valid, bus_e.busy, bus_e.in_ready}, 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int          n;
    int          sent;
    int          got;
    int          cyc;
    logic        acc_fire;
    logic        out_fire;
    logic [31:0] exp_v;
    logic [31:0] q[$];

    rst = 1'b1;
    bus_e.in_valid = 1'b0; bus_e.a = '0; bus_e.b = '0; bus_e.out_ready = 1'b0;
    bus_f.in_valid = 1'b0; bus_f.a = '0; bus_f.b = '0; bus_f.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_e", {bus_e.product}, 32'd0);
    check("rst_e_flags", {29'd0, bus_e.out_valid, bus_e.busy, bus_e.in_ready}, 32'd0);
    check("rst_f_flags", {29'd0, bus_f.out_valid, bus_f.busy, bus_f.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_rdy", {30'd0, bus_e.in_ready, bus_f.in_ready}, 32'd3);

    // Directed products and latencies on the early-exit unit
    op_e(32'd3, 32'd5, 32'd15, 32'd3, "t1");
    op_e(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'd32, "t2");
    op_e(32'h1234, 32'd0, 32'd0, 32'd1, "t3a");
    op_e(32'd0, 32'h8000_0000, 32'd0, 32'd32, "t3b");
    op_e(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd17, "wrap");
    op_e(32'hDEAD_BEEF, 32'd3, 32'h9C09_3CCD, 32'd2, "deadx3");

    // Hold the result in DONE with in_valid pulses that must be ignored
    bus_e.in_valid = 1'b1; bus_e.a = 32'd6; bus_e.b = 32'd7;
    @(posedge clk); #1;
    bus_e.in_valid = 1'b0;
    n = 0;
    while (!bus_e.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_lat", n, 32'd3);
    for (int i = 0; i < 10; i++) begin
      bus_e.in_valid = ((i % 2) == 0);
      bus_e.a        = $urandom;
      bus_e.b        = $urandom;
      @(posedge clk); #1;
      check("t4_hold_prod", bus_e.product, 32'd42);
      check("t4_hold_flags", {30'd0, bus_e.out_valid, bus_e.in_ready}, 32'd2);
    end
    bus_e.in_valid  = 1'b0;
    bus_e.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_e.out_ready = 1'b0;
    check("t4_release", {29'd0, bus_e.out_valid, bus_e.busy, bus_e.in_ready}, 32'd1);

    // Reset in the middle of BUSY drops the operation
    bus_e.in_valid = 1'b1; bus_e.a = 32'd7; bus_e.b = 32'h0000_FFFF;
    @(posedge clk); #1;
    bus_e.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("t5_busy", {30'd0, bus_e.busy, bus_e.out_valid}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5_prod", bus_e.product, 32'd0);
    check("t5_flags", {29'd0, bus_e.out_valid, bus_e.busy, bus_e.in_ready}, 32'd1);
    @(posedge clk); #1;
    op_e(32'd6, 32'd7, 32'd42, 32'd3, "t5_after");

    // Full-length unit: fixed 32-step latency
    bus_f.in_valid = 1'b1; bus_f.a = 32'd2; bus_f.b = 32'd1;
    @(posedge clk); #1;
    bus_f.in_valid = 1'b0;
    n = 0;
    while (!bus_f.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_lat", n, 32'd32);
    check("t6_prod", bus_f.product, 32'd2);
    bus_f.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_f.out_ready = 1'b0;

    // Back-to-back stream with random consumer stalls, in-order scoreboard
    sent = 0; got = 0; cyc = 0;
    bus_f.in_valid  = 1'b1;
    bus_f.a         = $urandom;
    bus_f.b         = $urandom;
    bus_f.out_ready = ($urandom_range(0, 3) != 0);
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      acc_fire = bus_f.in_valid && bus_f.in_ready;
      out_fire = bus_f.out_valid && bus_f.out_ready;
      if (acc_fire) begin
        exp_v = bus_f.a * bus_f.b;
        q.push_back(exp_v);
        sent++;
      end
      if (out_fire) begin
        check("rnd_nonempty", {31'd0, (q.size() != 0)}, 32'd1);
        if (q.size() != 0) check("rnd_prod", bus_f.product, q.pop_front());
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_fire) begin
        if (sent < 1000) begin
          bus_f.a = $urandom;
          bus_f.b = $urandom;
        end else begin
          bus_f.in_valid = 1'b0;
        end
      end
      bus_f.out_ready = ($urandom_range(0, 3) != 0);
    end
    check("rnd_count", got, 32'd1000);
    check("rnd_sent", sent, 32'd1000);
    check("rnd_left", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
